// File: rtl/axi_rd_split_pkg.sv
// axi_rd_split_pkg: shared constants, tracking entry type and 4 KiB boundary helper
package axi_rd_split_pkg;
  localparam int BOUNDARY_BYTES = 4096;
  typedef struct packed {
    logic last;
  } split_entry_t;
  function automatic logic [12:0] beats_to_boundary(input logic [11:0] addr, input int bytes_per_beat);
    return 13'((BOUNDARY_BYTES - int'(addr)) / bytes_per_beat);
  endfunction
endpackage

// File: rtl/axi_rd_split_fifo.sv
// axi_rd_split_fifo: synchronous FIFO tracking the last flag of each outstanding sub-burst
module axi_rd_split_fifo
  import axi_rd_split_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic         bcd_clk,
  input  logic         bcd_reset,
  input  logic         push,
  input  logic         pop,
  input  split_entry_t din,
  output split_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  split_entry_t mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge bcd_clk) begin
    if (bcd_reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
endmodule

// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter: splits AXI4 read bursts at 4 KiB / MAX_BEATS, re-merges rlast; AXI_RD_SPLIT_STATS_EN adds counters
module axi_rd_burst_splitter
  import axi_rd_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BEATS  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  bcd_clk,
  input  logic                  bcd_reset,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast
`ifdef AXI_RD_SPLIT_STATS_EN
  ,
  output logic [31:0]           stat_req_count,
  output logic [31:0]           stat_sub_count
`endif
);
  localparam int BPB  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [8:0] rem, rem_n, chunk;
  logic [7:0] arlen, arlen_n;
  logic s_hs, ar_hs, full, empty, unused_ok;
  split_entry_t head;
  function automatic logic [8:0] chunk_of(input logic [11:0] lo, input logic [8:0] r);
    logic [12:0] c, b;
    b = beats_to_boundary(lo, BPB);
    c = {4'd0, r};
    c = (13'(MAX_BEATS) < c) ? 13'(MAX_BEATS) : c;
    c = (b < c) ? b : c;
    return c[8:0];
  endfunction
  assign chunk         = chunk_of(addr[11:0], rem);
  assign s_axi_arready = (state == IDLE) && !bcd_reset;
  assign m_axi_arvalid = (state == ISSUE) && !full;
  assign s_hs          = s_axi_arvalid && s_axi_arready;
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = arlen;
  assign m_axi_arsize  = 3'(SIZE);
  assign unused_ok     = ^s_axi_arsize;
  always_ff @(posedge bcd_clk) begin
    if (bcd_reset) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
      arlen <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      rem   <= rem_n;
      arlen <= arlen_n;
    end
  end
  // arlen is precomputed for the next payload so the AR outputs stay registered
  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    if (s_hs) begin
      addr_n  = s_axi_araddr;
      rem_n   = {1'b0, s_axi_arlen} + 9'd1;
      state_n = ISSUE;
    end else if (ar_hs) begin
      addr_n  = addr + (ADDR_WIDTH'(chunk) << SIZE);
      rem_n   = rem - chunk;
      state_n = (rem == chunk) ? IDLE : ISSUE;
    end
    arlen_n = 8'(chunk_of(addr_n[11:0], rem_n) - 9'd1);
  end
  axi_rd_split_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .bcd_clk  (bcd_clk),
    .bcd_reset(bcd_reset),
    .push     (ar_hs),
    .pop      (m_axi_rvalid && m_axi_rready && m_axi_rlast),
    .din      ('{last: rem == chunk}),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast && !empty && head.last;
`ifdef AXI_RD_SPLIT_STATS_EN
  always_ff @(posedge bcd_clk) begin
    if (bcd_reset) begin
      stat_req_count <= '0;
      stat_sub_count <= '0;
    end else begin
      if (s_hs && stat_req_count != '1) stat_req_count <= stat_req_count + 1'b1;
      if (ar_hs && stat_sub_count != '1) stat_sub_count <= stat_sub_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// tb_axi_rd_burst_splitter: directed bench with a request-level split model and a downstream slave
module tb_axi_rd_burst_splitter;
  logic bcd_clk = 0, bcd_reset;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [63:0] s_axi_araddr, m_axi_araddr;
  logic [7:0] s_axi_arlen, m_axi_arlen;
  logic [2:0] s_axi_arsize, m_axi_arsize;
  logic [511:0] s_axi_rdata, m_axi_rdata;
  logic [1:0] s_axi_rresp, m_axi_rresp;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
`ifdef AXI_RD_SPLIT_STATS_EN
  logic [31:0] stat_req_count, stat_sub_count;
`endif
  always #5 bcd_clk = ~bcd_clk;

  axi_rd_burst_splitter #(.ADDR_WIDTH(64), .DATA_WIDTH(512), .MAX_BEATS(64), .FIFO_DEPTH(2)) dut (
    .bcd_clk(bcd_clk), .bcd_reset(bcd_reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
`ifdef AXI_RD_SPLIT_STATS_EN
    , .stat_req_count(stat_req_count), .stat_sub_count(stat_sub_count)
`endif
  );

  typedef struct {longint unsigned a; int len; bit last;} sub_t;
  sub_t exp_q[$];
  sub_t sub_log[$];
  int req_q[$];
  int vec = 0, err = 0;
  int subs_seen = 0, up_lasts = 0, up_beats = 0, up_cnt = 0;
  bit r_en = 1, ar_rand = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Request-level reference: split by 64-beat limit and 4 KiB pages of 64-byte beats
  task automatic model_split(input longint unsigned a, input int n);
    int b, c;
    while (n > 0) begin
      b = int'((64'd4096 - (a % 64'd4096)) / 64'd64);
      c = n < 64 ? n : 64;
      c = b < c ? b : c;
      exp_q.push_back('{a, c - 1, n == c});
      a += longint'(c) * 64;
      n -= c;
    end
  endtask

  bit prev_stall = 0;
  logic [63:0] prev_addr;
  logic [7:0] prev_len;
  always @(negedge bcd_clk) begin
    if (bcd_reset) begin
      exp_q.delete();
      req_q.delete();
      up_cnt = 0;
      prev_stall = 0;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        model_split(s_axi_araddr, int'(s_axi_arlen) + 1);
        req_q.push_back(int'(s_axi_arlen) + 1);
      end
      if (prev_stall) begin
        chk("ar_hold_valid", m_axi_arvalid, 1'b1);
        chk("ar_hold_addr", m_axi_araddr, prev_addr);
        chk("ar_hold_len", m_axi_arlen, prev_len);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_q.size() == 0) begin
          vec++;
          err++;
          $display("FAIL ar_unexpected: got addr %0h len %0d expected no sub-burst", m_axi_araddr, m_axi_arlen);
        end else begin
          sub_t e;
          e = exp_q.pop_front();
          chk("sub_addr", m_axi_araddr, e.a);
          chk("sub_len", m_axi_arlen, e.len);
        end
        sub_log.push_back('{m_axi_araddr, int'(m_axi_arlen), 0});
        subs_seen++;
      end
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev_addr = m_axi_araddr;
      prev_len = m_axi_arlen;
      chk("r_valid_pass", s_axi_rvalid, m_axi_rvalid);
      chk("r_ready_pass", m_axi_rready, s_axi_rready);
      if (m_axi_rvalid && m_axi_rready) begin
        bit exp_last;
        exp_last = req_q.size() > 0 && up_cnt == req_q[0] - 1;
        chk("r_data", s_axi_rdata, m_axi_rdata);
        chk("r_resp", s_axi_rresp, m_axi_rresp);
        chk("r_last", s_axi_rlast, exp_last);
        up_cnt++;
        up_beats++;
        if (exp_last) begin
          void'(req_q.pop_front());
          up_cnt = 0;
        end
        if (s_axi_rlast) up_lasts++;
      end
    end
  end

  // Downstream slave: answers each accepted sub-burst in order with arlen+1 beats
  int sq[$];
  int bi = 0;
  initial begin
    bit ar, r, rst;
    int al;
    forever begin
      @(negedge bcd_clk);
      ar = m_axi_arvalid && m_axi_arready;
      al = int'(m_axi_arlen) + 1;
      r = m_axi_rvalid && m_axi_rready;
      rst = bcd_reset;
      @(posedge bcd_clk);
      #2;
      if (rst) begin
        sq.delete();
        bi = 0;
      end else begin
        if (r) begin
          bi++;
          if (bi == sq[0]) begin
            void'(sq.pop_front());
            bi = 0;
          end
        end
        if (ar) sq.push_back(al);
      end
      m_axi_rvalid = r_en && sq.size() > 0;
      m_axi_rlast = sq.size() > 0 && bi == sq[0] - 1;
      m_axi_rdata = {16{$urandom()}};
      m_axi_rresp = 2'(bi);
      m_axi_arready = ar_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic send_ar(input longint unsigned a, input int len);
    bit hs = 0;
    @(posedge bcd_clk);
    #1;
    s_axi_arvalid = 1;
    s_axi_araddr = a;
    s_axi_arlen = 8'(len);
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge bcd_clk);
      hs = s_axi_arready;
    end
    @(posedge bcd_clk);
    #1;
    s_axi_arvalid = 0;
    chk("ar_accept", hs, 1'b1);
  endtask

  task automatic run_req(input longint unsigned a, input int len, input int nsub);
    int s0, l0, b0;
    s0 = subs_seen;
    l0 = up_lasts;
    b0 = up_beats;
    send_ar(a, len);
    for (int i = 0; i < 3000 && up_lasts == l0; i++) @(negedge bcd_clk);
    repeat (3) @(negedge bcd_clk);
    chk("req_subs", subs_seen - s0, nsub);
    chk("req_beats", up_beats - b0, len + 1);
    chk("req_rlasts", up_lasts - l0, 1);
  endtask

  task automatic chk_sub(input int idx, input longint unsigned a, input int len);
    if (idx < sub_log.size()) begin
      chk("lit_addr", sub_log[idx].a, a);
      chk("lit_len", sub_log[idx].len, len);
    end else begin
      vec++;
      err++;
      $display("FAIL lit_missing: got %0d sub-bursts expected index %0d", sub_log.size(), idx);
    end
  endtask

  initial begin
    int s0, base;
    bcd_reset = 1;
    s_axi_arvalid = 0;
    s_axi_araddr = 0;
    s_axi_arlen = 0;
    s_axi_arsize = 3'd6;
    s_axi_rready = 1;
    m_axi_arready = 1;
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    m_axi_rdata = 0;
    m_axi_rresp = 0;
    repeat (3) @(posedge bcd_clk);
    @(negedge bcd_clk);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", m_axi_arlen, 8'd0);
    chk("arsize", m_axi_arsize, 3'd6);
    @(posedge bcd_clk);
    #1;
    bcd_reset = 0;
    @(negedge bcd_clk);
    chk("post_rst_arready", s_axi_arready, 1'b1);

    base = sub_log.size();
    run_req(64'h0, 15, 1);
    chk_sub(base, 64'h0, 15);

    ar_rand = 1;
    base = sub_log.size();
    run_req(64'h0, 255, 4);
    chk_sub(base, 64'h0, 63);
    chk_sub(base + 1, 64'h1000, 63);
    chk_sub(base + 2, 64'h2000, 63);
    chk_sub(base + 3, 64'h3000, 63);
    ar_rand = 0;

    base = sub_log.size();
    run_req(64'hFC0, 3, 2);
    chk_sub(base, 64'hFC0, 0);
    chk_sub(base + 1, 64'h1000, 2);
`ifdef AXI_RD_SPLIT_STATS_EN
    chk("stat_req", stat_req_count, 32'd3);
    chk("stat_sub", stat_sub_count, 32'd7);
`endif

    r_en = 0;
    s0 = subs_seen;
    send_ar(64'h4000, 255);
    repeat (10) @(negedge bcd_clk);
    chk("bp_subs", subs_seen - s0, 2);
    chk("bp_arvalid", m_axi_arvalid, 1'b0);
    r_en = 1;
    for (int i = 0; i < 200 && subs_seen - s0 < 3; i++) @(negedge bcd_clk);
    chk("bp_third", subs_seen - s0 >= 3, 1'b1);
    for (int i = 0; i < 3000 && subs_seen - s0 < 4; i++) @(negedge bcd_clk);
    repeat (300) @(negedge bcd_clk);
    chk("bp_total", subs_seen - s0, 4);

    r_en = 0;
    s0 = subs_seen;
    send_ar(64'h0, 255);
    for (int i = 0; i < 50 && subs_seen - s0 < 2; i++) @(negedge bcd_clk);
    chk("mid_subs", subs_seen - s0, 2);
    @(posedge bcd_clk);
    #1;
    bcd_reset = 1;
    @(negedge bcd_clk);
    chk("mid_rst_arready", s_axi_arready, 1'b0);
    @(negedge bcd_clk);
    chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
    @(posedge bcd_clk);
    #1;
    bcd_reset = 0;
    @(negedge bcd_clk);
    chk("mid_post_arready", s_axi_arready, 1'b1);
    r_en = 1;
    base = sub_log.size();
    run_req(64'h40, 0, 1);
    chk_sub(base, 64'h40, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/axi_rd_burst_splitter.md
# axi_rd_burst_splitter

Read-channel AXI4 burst splitter placed between the Fletcher kernel's AXI master read port and the DMA PCIS interconnect master port. It accepts arbitrary-length full-width read bursts and reissues them as legal sub-bursts. Each sub-burst never crosses a 4 KiB boundary and never exceeds `MAX_BEATS`. The R stream passes through, with `rlast` re-merged so the upstream master sees exactly one `rlast` per original request.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 512: data width. Beat size is `DATA_WIDTH/8` bytes.
- `MAX_BEATS`, 64: maximum beats per issued sub-burst. Power of two, 1..256.
- `FIFO_DEPTH`, 16: number of outstanding sub-bursts tracked. Power of two, ≥2.

Ports:
- `bcd_clk`, in, 1: the single clock.
- `bcd_reset`, in, 1: synchronous, active-high reset.
- `s_axi_arvalid`/`s_axi_arready`, in/out, 1/1: upstream AR handshake.
- `s_axi_araddr`, in, ADDR_WIDTH: start address. Must be beat-aligned.
- `s_axi_arlen`, in, 8: original length minus 1.
- `s_axi_arsize`, in, 3: must equal log2(DATA_WIDTH/8). Ignored internally.
- `s_axi_rvalid`/`s_axi_rready`, out/in, 1/1: upstream R handshake.
- `s_axi_rdata`, out, DATA_WIDTH.
- `s_axi_rresp`, out, 2.
- `s_axi_rlast`, out, 1.
- `m_axi_arvalid`/`m_axi_arready`, out/in, 1/1: downstream AR handshake.
- `m_axi_araddr`, out, ADDR_WIDTH.
- `m_axi_arlen`, out, 8.
- `m_axi_arsize`, out, 3: constant log2(DATA_WIDTH/8).
- `m_axi_rvalid`/`m_axi_rready`, in/out, 1/1.
- `m_axi_rdata`, in, DATA_WIDTH.
- `m_axi_rresp`, in, 2.
- `m_axi_rlast`, in, 1.

## Operation
- FSM states:
  - IDLE: `s_axi_arready`=1. A handshake latches `addr` and `remaining = arlen+1` (9 bits), then moves to ISSUE.
  - ISSUE: `s_axi_arready`=0. Computes `chunk = min(remaining, MAX_BEATS, (4096 - addr[11:0]) / BYTES_PER_BEAT)`.
- Sub-burst issue: `m_axi_arvalid` is asserted only when the tracking FIFO is not full. `m_axi_araddr`=addr and `m_axi_arlen`=chunk-1, both registered.
- On the `m_axi_ar` handshake:
  - push `{last = (remaining == chunk)}` into the FIFO;
  - `addr += chunk*BYTES_PER_BEAT`;
  - `remaining -= chunk`;
  - if last, go to IDLE; otherwise stay in ISSUE and recompute.
- The AR payload is held stable while `m_axi_arvalid` is high and `m_axi_arready` is low.
- R path is combinational pass-through:
  - `s_axi_rvalid`=`m_axi_rvalid`, `m_axi_rready`=`s_axi_rready`;
  - `rdata` and `rresp` are passed unmodified per beat;
  - `s_axi_rlast` = `m_axi_rlast` & FIFO-head `last`.
- FIFO pop: on `m_axi_rvalid & m_axi_rready & m_axi_rlast`.
- Downstream responses are required to be in order (single ID). The block drives no ID.
- Simultaneous push and pop on a full FIFO: the pop frees an entry only in the next cycle, so no push occurs in that cycle.
- An `m_axi_rvalid` arriving with the FIFO empty is a protocol violation. The beat is passed with `s_axi_rlast`=0.

## Timing
- Reset values: `s_axi_arready`=0, `m_axi_arvalid`=0, `m_axi_araddr`=0, `m_axi_arlen`=0, FIFO empty, state IDLE. `s_axi_arready` rises in the first cycle after reset deasserts.
- AR latency: `m_axi_arvalid` first rises one cycle after the `s_axi_ar` handshake.
- Back-to-back sub-bursts: one per cycle while `m_axi_arready`=1 and the FIFO has space.
- R latency: zero cycles, purely combinational.
- A new upstream request is accepted no earlier than one cycle after the final sub-burst handshake.
- Reset mid-operation: all state, the FIFO and the counters clear. In-flight downstream data is not recovered. The surrounding CL resets both sides together.

## Configuration
- Macro `AXI_RD_SPLIT_STATS_EN`.
- When defined, adds output ports:
  - `stat_req_count`, 32: incremented on each `s_axi_ar` handshake.
  - `stat_sub_count`, 32: incremented on each `m_axi_ar` handshake.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `axi_rd_split_pkg` holds:
  - constants `BOUNDARY_BYTES`=4096;
  - function `beats_to_boundary(addr, bytes_per_beat)`;
  - typedef `split_entry_t` (1-bit `last`).
- Sub-module `axi_rd_split_fifo` provides synchronous FIFO storage of `split_entry_t`, with `full`/`empty`, depth `FIFO_DEPTH`, and the same clock and reset.

## Test plan
- **Aligned short burst.** araddr=0x0, arlen=15 -> one sub-burst, araddr 0x0, arlen 15. `s_axi_rlast` asserts on beat 16 only.
- **Long burst, length limit.** araddr=0x0, arlen=255, MAX_BEATS=64 -> four sub-bursts at 0x0, 0x1000, 0x2000, 0x3000, each arlen 63. Exactly one `s_axi_rlast`, on beat 256.
- **4K crossing.** araddr=0xFC0, arlen=3 -> sub-burst at 0xFC0 with arlen 0, then at 0x1000 with arlen 2. Exactly 4 beats upstream, with rlast on the 4th.
- **FIFO backpressure.** FIFO_DEPTH=2, `m_axi_rvalid` held 0, request arlen=255 -> exactly 2 sub-bursts issued, then `m_axi_arvalid` stays 0. Completing one downstream burst allows the 3rd to issue.
- **Reset mid-split.** Assert `bcd_reset` after the 2nd of 4 sub-bursts -> next cycle `m_axi_arvalid`=0 and FIFO empty. `s_axi_arready`=1 in the cycle after reset deasserts.
- **Stats (AXI_RD_SPLIT_STATS_EN).** Scenarios 1-3 in sequence -> `stat_req_count`=3, `stat_sub_count`=7.
